// File: rtl/div_arbiter.sv
// rtl/div_arbiter.sv - round-robin arbiter sharing one sequential signed divider between two ports
//
// Purpose: grants one of two requesters access to a start/done signed divider,
// launches the operation, captures the result (or a watchdog abort) into the
// granted port's result registers and pulses that port's done.
//
// Ports:
//   clk, reset                  clock, synchronous active-low reset
//   req0/req1                   level requests, held until the matching done
//   a0/b0, a1/b1                per-port signed dividend/divisor
//   done0/done1                 one-cycle completion pulses
//   q0/r0, q1/r1                per-port quotient/remainder, held until next completion
//   err0/err1                   per-port error qualifier (timeout or divide-by-zero bypass)
//   busy                        high whenever the arbiter is not idle
//   div_start, div_a, div_b     divider launch pulse and latched operands
//   div_quotient/div_remainder  divider results
//   div_done                    divider completion, only honoured while waiting
//
// Build option: DIV_ZERO_BYPASS_EN - a granted request with divisor 0 is
// answered immediately with q=r=0, err=1 and never reaches the divider.

module div_arbiter #(
  parameter int WIDTH     = 8,
  parameter int RES_WIDTH = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req0,
  input  logic                        req1,
  input  logic signed [WIDTH-1:0]     a0,
  input  logic signed [WIDTH-1:0]     b0,
  input  logic signed [WIDTH-1:0]     a1,
  input  logic signed [WIDTH-1:0]     b1,
  output logic                        done0,
  output logic                        done1,
  output logic signed [RES_WIDTH-1:0] q0,
  output logic signed [RES_WIDTH-1:0] r0,
  output logic signed [RES_WIDTH-1:0] q1,
  output logic signed [RES_WIDTH-1:0] r1,
  output logic                        err0,
  output logic                        err1,
  output logic                        busy,
  output logic                        div_start,
  output logic signed [WIDTH-1:0]     div_a,
  output logic signed [WIDTH-1:0]     div_b,
  input  logic signed [RES_WIDTH-1:0] div_quotient,
  input  logic signed [RES_WIDTH-1:0] div_remainder,
  input  logic                        div_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  // Last WAIT cycle index before the watchdog gives up.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e                      state_q, state_d;
  logic                        last_q, last_d;
  logic                        gnt_q, gnt_d;
  logic [7:0]                  cnt_q, cnt_d;
  logic signed [WIDTH-1:0]     div_a_q, div_a_d;
  logic signed [WIDTH-1:0]     div_b_q, div_b_d;
  logic signed [RES_WIDTH-1:0] q0_q, q0_d, r0_q, r0_d;
  logic signed [RES_WIDTH-1:0] q1_q, q1_d, r1_q, r1_d;
  logic                        err0_q, err0_d, err1_q, err1_d;

  logic                        win;
  logic signed [WIDTH-1:0]     win_a;
  logic signed [WIDTH-1:0]     win_b;
  logic                        cap_en;
  logic signed [RES_WIDTH-1:0] cap_quo;
  logic signed [RES_WIDTH-1:0] cap_rem;
  logic                        cap_err;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    div_a_d = div_a_q;
    div_b_d = div_b_q;
    q0_d    = q0_q;
    r0_d    = r0_q;
    q1_d    = q1_q;
    r1_d    = r1_q;
    err0_d  = err0_q;
    err1_d  = err1_q;
    cap_en  = 1'b0;
    cap_quo = div_quotient;
    cap_rem = div_remainder;
    cap_err = 1'b0;

    // On a tie the port that was not served last wins; a lone request wins outright.
    win   = (req0 && req1) ? ~last_q : req1;
    win_a = win ? a1 : a0;
    win_b = win ? b1 : b0;

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          gnt_d = win;
`ifdef DIV_ZERO_BYPASS_EN
          if (win_b == '0) begin
            cap_en  = 1'b1;
            cap_quo = '0;
            cap_rem = '0;
            cap_err = 1'b1;
            state_d = S_RESP;
          end else begin
            div_a_d = win_a;
            div_b_d = win_b;
            state_d = S_ISSUE;
          end
`else
          div_a_d = win_a;
          div_b_d = win_b;
          state_d = S_ISSUE;
`endif
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A result arriving on the final watchdog cycle still wins over the abort.
        if (div_done) begin
          cap_en  = 1'b1;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          cap_en  = 1'b1;
          cap_quo = '0;
          cap_rem = '0;
          cap_err = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RESP: begin
        last_d  = gnt_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Capture targets gnt_d so the bypass path (granted this same cycle) lands correctly.
    if (cap_en) begin
      if (gnt_d) begin
        q1_d   = cap_quo;
        r1_d   = cap_rem;
        err1_d = cap_err;
      end else begin
        q0_d   = cap_quo;
        r0_d   = cap_rem;
        err0_d = cap_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      cnt_q   <= '0;
      div_a_q <= '0;
      div_b_q <= '0;
      q0_q    <= '0;
      r0_q    <= '0;
      q1_q    <= '0;
      r1_q    <= '0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      div_a_q <= div_a_d;
      div_b_q <= div_b_d;
      q0_q    <= q0_d;
      r0_q    <= r0_d;
      q1_q    <= q1_d;
      r1_q    <= r1_d;
      err0_q  <= err0_d;
      err1_q  <= err1_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign div_start = (state_q == S_ISSUE);
  assign done0     = (state_q == S_RESP) && !gnt_q;
  assign done1     = (state_q == S_RESP) &&  gnt_q;
  assign div_a     = div_a_q;
  assign div_b     = div_b_q;
  assign q0        = q0_q;
  assign r0        = r0_q;
  assign q1        = q1_q;
  assign r1        = r1_q;
  assign err0      = err0_q;
  assign err1      = err1_q;

endmodule

// File: tb/tb_div_arbiter.sv
// tb/tb_div_arbiter.sv - self-checking bench for div_arbiter with a timeline reference model
`timescale 1ns/1ps
module tb_div_arbiter;
  localparam int W  = 8;
  localparam int RW = 16;
  localparam int T  = 16;
`ifdef DIV_ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic req0, req1;
  logic signed [W-1:0]  a0, b0, a1, b1;
  logic done0, done1, err0, err1, busy, div_start, div_done;
  logic signed [RW-1:0] q0, r0, q1, r1, div_quotient, div_remainder;
  logic signed [W-1:0]  div_a, div_b;

  always #5 clk = ~clk;

  div_arbiter #(.WIDTH(W), .RES_WIDTH(RW), .TIMEOUT(T)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .done0(done0), .done1(done1), .q0(q0), .r0(r0), .q1(q1), .r1(r1),
    .err0(err0), .err1(err1), .busy(busy), .div_start(div_start),
    .div_a(div_a), .div_b(div_b),
    .div_quotient(div_quotient), .div_remainder(div_remainder), .div_done(div_done)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit chk_en = 0;

  // Requesters
  bit pend[2];
  logic signed [W-1:0] pa[2], pb[2];
  // Current operation timeline
  bit op_on = 0, op_byp = 0, op_tmo = 0;
  int t0 = 0, t_resp = 0, gp = 0, last = 1;
  logic signed [W-1:0]  op_a, op_b;
  logic signed [RW-1:0] res_q, res_r;
  bit res_err;
  // Expected outputs
  bit e_done[2];
  logic signed [RW-1:0] e_q[2], e_r[2];
  bit e_err[2];
  bit e_busy, e_start;
  logic signed [W-1:0] e_da, e_db;
  // Knobs
  int p_new = 0, p_keep = 0, d_max = 20, force_d = -1, p_rst = 0;
  bit noise_en = 1, kick = 0, rst_req = 0, rst_pending = 1;

  task automatic chk(input string nm, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, got, exp);
    end
  endtask

  function automatic logic signed [W-1:0] rand_b();
    int k;
    k = $urandom_range(9);
    if (k < 2) return '0;
    if (k == 2) return -8'sd1;
    return W'($urandom);
  endfunction

  task automatic step();
    bit resp_now;
    bit do_rst;
    int dl;
    @(posedge clk); #1;
    cyc++;
    resp_now = 0;
    if (rst_pending) begin
      rst_pending = 0;
      op_on = 0;
      last = 1;
      for (int p = 0; p < 2; p++) begin e_q[p] = '0; e_r[p] = '0; e_err[p] = 0; end
      e_da = '0;
      e_db = '0;
    end
    e_done[0] = 0;
    e_done[1] = 0;
    e_busy  = op_on && (cyc >= t0 + 1);
    e_start = op_on && !op_byp && (cyc == t0 + 1);
    if (e_start) begin e_da = op_a; e_db = op_b; end
    if (op_on && cyc == t_resp) begin
      resp_now   = 1;
      e_done[gp] = 1;
      e_q[gp]    = res_q;
      e_r[gp]    = res_r;
      e_err[gp]  = res_err;
      last       = gp;
    end

    // Divider: quiet while computing, answers D cycles after start, noise otherwise.
    if (op_on && !op_byp && cyc >= t0 + 2 && cyc < t_resp) begin
      div_done      = !op_tmo && (cyc == t_resp - 1);
      div_quotient  = div_done ? res_q : RW'($urandom);
      div_remainder = div_done ? res_r : RW'($urandom);
    end else begin
      div_done      = kick || (noise_en && $urandom_range(3) == 0);
      div_quotient  = RW'($urandom);
      div_remainder = RW'($urandom);
    end
    kick = 0;

    if (resp_now) begin
      if ($urandom_range(99) >= p_keep) pend[gp] = 0;
      op_on = 0;
    end
    for (int p = 0; p < 2; p++) begin
      if (!pend[p] && !(resp_now && p == gp) && $urandom_range(99) < p_new) begin
        pend[p] = 1;
        pa[p]   = W'($urandom);
        pb[p]   = rand_b();
      end
    end
    do_rst  = rst_req || (p_rst > 0 && $urandom_range(999) < p_rst);
    rst_req = 0;
    if (do_rst) begin
      pend[0] = 0;
      pend[1] = 0;
      rst_pending = 1;
    end else if (!op_on && !resp_now && (pend[0] || pend[1])) begin
      if (pend[0] && pend[1]) gp = (last == 1) ? 0 : 1;
      else gp = pend[1] ? 1 : 0;
      t0     = cyc;
      op_a   = pa[gp];
      op_b   = pb[gp];
      op_byp = BYPASS && (op_b == 0);
      dl     = (force_d >= 0) ? force_d : $urandom_range(d_max, 1);
      op_tmo = 0;
      if (op_byp) begin
        t_resp = t0 + 1; res_q = '0; res_r = '0; res_err = 1;
      end else if (dl > T) begin
        t_resp = t0 + 2 + T; res_q = '0; res_r = '0; res_err = 1; op_tmo = 1;
      end else begin
        t_resp  = t0 + 2 + dl;
        res_err = 0;
        if (op_b == 0) begin
          res_q = '0; res_r = '0;
        end else begin
          res_q = RW'(int'(op_a) / int'(op_b));
          res_r = RW'(int'(op_a) % int'(op_b));
        end
      end
      op_on = 1;
    end
    reset = !do_rst;
    req0  = pend[0];
    req1  = pend[1];
    a0 = pa[0]; b0 = pb[0]; a1 = pa[1]; b1 = pb[1];
  endtask

  task automatic quiesce();
    p_new = 0;
    p_keep = 0;
    for (int i = 0; i < 300 && (op_on || pend[0] || pend[1]); i++) step();
  endtask

  task automatic wait_done(input int port, input int bound, output int lat);
    lat = -1;
    for (int i = 0; i < bound; i++) begin
      step();
      if ((port == 0 && done0 === 1'b1) || (port == 1 && done1 === 1'b1)) begin
        lat = cyc - t0;
        return;
      end
    end
    n_vec++;
    n_err++;
    $display("FAIL wait_done port=%0d no completion within %0d cycles", port, bound);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("done0", done0, e_done[0]);
      chk("done1", done1, e_done[1]);
      chk("q0", q0, e_q[0]);
      chk("r0", r0, e_r[0]);
      chk("q1", q1, e_q[1]);
      chk("r1", r1, e_r[1]);
      chk("err0", err0, e_err[0]);
      chk("err1", err1, e_err[1]);
      chk("busy", busy, e_busy);
      chk("div_start", div_start, e_start);
      chk("div_a", div_a, e_da);
      chk("div_b", div_b, e_db);
    end
  end

  initial begin
    int lat;
    int order[6];
    int nd;
    reset = 0; req0 = 0; req1 = 0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    div_done = 0; div_quotient = '0; div_remainder = '0;
    pend[0] = 0; pend[1] = 0;
    pa[0] = '0; pb[0] = '0; pa[1] = '0; pb[1] = '0;

    step();
    chk_en = 1;
    chk("rst_busy", busy, 0);
    chk("rst_q0", q0, 0);
    chk("rst_div_a", div_a, 0);

    // Port 0 25/5 with divider latency 8
    pend[0] = 1; pa[0] = 8'sd25; pb[0] = 8'sd5; force_d = 8;
    wait_done(0, 40, lat);
    chk("t1_lat", lat, 10);
    chk("t1_q0", q0, 5);
    chk("t1_r0", r0, 0);
    chk("t1_err0", err0, 0);
    chk("t1_q1", q1, 0);
    quiesce();

    // Simultaneous requests right after reset
    rst_req = 1; step();
    pend[0] = 1; pa[0] = 8'sd127; pb[0] = 8'sd3;
    pend[1] = 1; pa[1] = -8'sd25; pb[1] = 8'sd5; force_d = 3;
    wait_done(0, 40, lat);
    chk("t2_q0", q0, 42);
    chk("t2_r0", r0, 1);
    chk("t2_q1_untouched", q1, 0);
    wait_done(1, 40, lat);
    chk("t2_q1", q1, -5);
    chk("t2_r1", r1, 0);
    quiesce();

    // Fairness with both held high
    rst_req = 1; step();
    pend[0] = 1; pa[0] = 8'sd9;  pb[0] = 8'sd2;
    pend[1] = 1; pa[1] = 8'sd20; pb[1] = 8'sd3;
    p_keep = 100; force_d = 2; nd = 0;
    for (int i = 0; i < 200 && nd < 6; i++) begin
      step();
      if (done0 === 1'b1) begin order[nd] = 0; nd++; end
      else if (done1 === 1'b1) begin order[nd] = 1; nd++; end
    end
    chk("t3_ndone", nd, 6);
    for (int i = 0; i < nd; i++) chk("t3_order", order[i], i % 2);
    quiesce();

    // Divide by zero on port 1
    pend[1] = 1; pa[1] = 8'sd5; pb[1] = 8'sd0; force_d = 4;
    wait_done(1, 40, lat);
    chk("t4_lat", lat, BYPASS ? 1 : 6);
    chk("t4_err1", err1, BYPASS ? 1 : 0);
    chk("t4_q1", q1, 0);
    chk("t4_r1", r1, 0);
    quiesce();

    // Watchdog boundary: D=T+1 aborts, D=T still completes
    pend[0] = 1; pa[0] = 8'sd7; pb[0] = 8'sd2; force_d = T + 1;
    wait_done(0, 60, lat);
    chk("t5_lat_tmo", lat, 18);
    chk("t5_err0_tmo", err0, 1);
    chk("t5_q0_tmo", q0, 0);
    quiesce();
    pend[0] = 1; pa[0] = 8'sd9; pb[0] = 8'sd4; force_d = T;
    wait_done(0, 60, lat);
    chk("t5_lat_edge", lat, 18);
    chk("t5_err0_edge", err0, 0);
    chk("t5_q0_edge", q0, 2);
    chk("t5_r0_edge", r0, 1);
    quiesce();

    // Reset mid-WAIT, then a stray div_done, then a normal request
    pend[0] = 1; pa[0] = 8'sd100; pb[0] = 8'sd9; force_d = 10;
    for (int i = 0; i < 40 && !(op_on && cyc >= t0 + 5); i++) step();
    rst_req = 1; step();
    kick = 1; step();
    chk("t6_busy", busy, 0);
    chk("t6_q0", q0, 0);
    chk("t6_err0", err0, 0);
    chk("t6_div_a", div_a, 0);
    step();
    chk("t6_busy_after_stray", busy, 0);
    pend[0] = 1; pa[0] = 8'sd54; pb[0] = 8'sd7; force_d = 5;
    wait_done(0, 40, lat);
    chk("t6_q0_new", q0, 7);
    chk("t6_r0_new", r0, 5);
    quiesce();

    // Randomised traffic
    force_d = -1; d_max = 20; p_new = 30; p_keep = 25; p_rst = 2;
    for (int i = 0; i < 4000; i++) begin
      p_new = 30; p_keep = 25;
      step();
    end
    p_rst = 0;
    quiesce();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
